// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: fetches the word at pc_in over a req/ack handshake,
// pulses instr_valid with the result, and registers the next PC for the PC register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] next_pc
);

  // Handshake: imem_req rises on entry to FETCH and stays high with imem_addr
  // constant until the cycle in which imem_ack is seen or the timeout expires;
  // imem_rdata is only looked at in a FETCH cycle with imem_ack high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_d;
  logic        err_d;
  logic [31:0] npc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4  = addr_q + 32'd4;
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr;
    err_d   = fetch_err;
    npc_d   = next_pc;
    case (state_q)
      IDLE: begin
        if (!stall) begin
          if (pc_in[1:0] == 2'b00) begin
            addr_d  = pc_in;
            cnt_d   = 8'd0;
            state_d = FETCH;
          end else begin
            // Misaligned: report an error without touching memory.
            addr_d  = {pc_in[31:2], 2'b00};
            instr_d = 32'h0;
            err_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == TMO_LAST) begin
          instr_d = 32'h0;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        if (jump)
          npc_d = {pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
          npc_d = branch_target;
        else
          npc_d = pc_plus4;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'h0;
      instr       <= 32'h0;
      fetch_err   <= 1'b0;
      next_pc     <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      instr       <= instr_d;
      fetch_err   <= err_d;
      next_pc     <= npc_d;
      // Strobes are registered from the next state so they line up with it.
      imem_req    <= (state_d == FETCH);
      instr_valid <= (state_d == HOLD);
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the multicycle MIPS soft core. Takes the current program counter from the PC register, fetches the addressed word from instruction memory over a req/ack handshake, and presents the instruction with a one-cycle valid pulse. It also computes the registered next-PC value (sequential, branch or jump) that feeds back into the PC register's data input, closing the fetch loop.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, reset value of next_pc
- TIMEOUT, 15, maximum FETCH cycles to wait for imem_ack before aborting (legal range 1..255)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- pc_in  in  32  current PC (PC register output)
- stall  in  1  holds the sequencer in IDLE; no new fetch is started
- imem_req  out  1  memory request
- imem_addr  out  32  word address of the request
- imem_ack  in  1  memory has driven imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- branch_taken  in  1  redirect to branch_target (sampled in HOLD)
- branch_target  in  32  full branch target address
- jump  in  1  redirect to the J-type target (sampled in HOLD)
- jump_index  in  26  J-type instr_index field
- instr  out  32  last fetched instruction (32'h0 = NOP on error)
- instr_valid  out  1  one-cycle pulse: instr and fetch_err are valid
- fetch_err  out  1  misaligned PC or memory timeout; qualified by instr_valid
- next_pc  out  32  registered next PC, drives PC register data input

## Operation
- States: IDLE, FETCH, HOLD. The reset state is IDLE.
- IDLE, stall=1: remain in IDLE.
- IDLE, stall=0, pc_in[1:0]==0: latch pc_in into the address register and go to FETCH.
- IDLE, stall=0, pc_in[1:0]!=0: go directly to HOLD with instr<=0 and fetch_err<=1. No memory request is issued.
- FETCH: imem_req=1 and imem_addr=latched address, both held constant until exit.
  - imem_ack=1: capture imem_rdata into instr, set fetch_err<=0, go to HOLD.
  - Otherwise the timeout counter increments. If the TIMEOUT-th consecutive FETCH cycle ends without ack: instr<=0, fetch_err<=1, go to HOLD.
  - Ack on the TIMEOUT-th cycle counts as success.
  - The timeout counter is cleared on every entry to FETCH.
- HOLD: instr_valid=1 for exactly this cycle. On the exiting edge, next_pc is updated and the state returns to IDLE.
- next_pc selection, in priority order:
  1. jump: {pc_plus4[31:28], jump_index, 2'b00}
  2. branch_taken: branch_target
  3. otherwise: pc_plus4
- pc_plus4 = latched address + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
- On a misaligned-PC error, the latched address is pc_in with bits [1:0] forced to 0.
- next_pc, instr and fetch_err hold their values between HOLD cycles.
- stall is ignored in FETCH and HOLD; a fetch in progress always completes.
- imem_rdata is ignored when imem_ack=0. imem_ack is ignored outside FETCH.

## Timing
- Reset values: imem_req=0, imem_addr=0, instr=0, instr_valid=0, fetch_err=0, next_pc=RESET_PC, state=IDLE, timeout counter=0.
- Reset has priority over everything, including mid-FETCH. imem_req drops on the cycle after rst is sampled, and any pending ack is discarded.
- Latency with zero-wait memory (ack in the first FETCH cycle): IDLE(start) -> FETCH -> HOLD -> IDLE.
  - instr_valid is high 2 cycles after the start edge.
  - next_pc is updated 3 cycles after the start edge.
  - This fits the PC register's 4-clock update window.
- With memory that acks after w wait cycles, all subsequent events shift by w cycles.
- Misaligned PC: instr_valid is high 1 cycle after the start edge.
- Timeout: HOLD is entered on the edge ending the TIMEOUT-th FETCH cycle.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, then pc_in=32'h0000_0040, stall=0, memory acks in the first cycle with 32'h2008_0005 -> imem_addr=0x40 while imem_req=1, instr=32'h2008_0005 with a one-cycle instr_valid, fetch_err=0, next_pc=32'h0000_0044.
- Same fetch, but jump=1 and branch_taken=1 during HOLD, jump_index=26'h000_0100, pc_in=32'h1000_0000 -> jump wins, next_pc=32'h1000_0400.
- Memory never acks, TIMEOUT=15 -> imem_req is high for exactly 15 cycles, then instr=0, fetch_err=1 on the instr_valid pulse, next_pc=pc+4. Repeat with ack on cycle 15 -> success, fetch_err=0.
- pc_in=32'h0000_0042 -> no imem_req, instr_valid one cycle after start with fetch_err=1, instr=0, next_pc=32'h0000_0044. Also pc_in=32'hFFFF_FFFC -> next_pc=32'h0000_0000.
- stall=1 for 5 cycles in IDLE -> imem_req stays 0. Assert stall mid-FETCH -> the fetch completes normally.
- Assert rst for 1 cycle in the third FETCH cycle -> imem_req=0 next cycle, all outputs return to reset values, and a late ack is ignored.
